// File: rtl/adc_sample_packer.sv
// Averages blocks of 2^DECIM_LOG2 three-channel ADC sample sets and writes each
// block as a two-word pair into an Avalon-MM FIFO, counting blocks lost to backpressure.
module adc_sample_packer #(
  parameter int DECIM_LOG2 = 2
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] reading0,
  input  logic [11:0] reading1,
  input  logic [11:0] reading2,
  input  logic        reading_valid,
  output logic [31:0] fifo_in_writedata,
  output logic        fifo_in_write,
  input  logic        fifo_in_waitrequest,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int AW = 12 + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);

  typedef enum logic [1:0] {ACCUM, WR0, WR1} state_e;

  state_e        state_q;
  logic [AW-1:0] acc0_q, acc1_q, acc2_q;
  logic [AW-1:0] acc0_d, acc1_d, acc2_d;
  logic [CW-1:0] cnt_q;
  logic [11:0]   avg0_d, avg1_d, avg2_d;
  logic [11:0]   avg2_q;
  logic [3:0]    seq_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic          busy_q;
  logic [15:0]   drop_q;
  logic          sampleTaken;
  logic          blockDone;
  logic          writeAccepted;

  // The completing sample is folded into the sums before the shift.
  always_comb begin
    acc0_d        = acc0_q + AW'(reading0);
    acc1_d        = acc1_q + AW'(reading1);
    acc2_d        = acc2_q + AW'(reading2);
    avg0_d        = 12'(acc0_d >> DECIM_LOG2);
    avg1_d        = 12'(acc1_d >> DECIM_LOG2);
    avg2_d        = 12'(acc2_d >> DECIM_LOG2);
    sampleTaken   = enable & reading_valid;
    blockDone     = sampleTaken & (cnt_q == CNT_LAST);
    writeAccepted = write_q & ~fifo_in_waitrequest;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      acc0_q <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
      cnt_q  <= '0;
    end else if (!enable || blockDone) begin
      acc0_q <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
      cnt_q  <= '0;
    end else if (reading_valid) begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Accumulation never pauses, so a block finishing outside ACCUM has nowhere to go.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      avg2_q  <= '0;
      seq_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (blockDone && state_q != ACCUM && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
      case (state_q)
        ACCUM: begin
          if (blockDone) begin
            avg2_q  <= avg2_d;
            wdata_q <= {4'hA, seq_q, avg1_d, avg0_d};
            write_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= WR0;
          end
        end
        WR0: begin
          if (writeAccepted) begin
            wdata_q <= {4'h5, seq_q, 12'h000, avg2_q};
            state_q <= WR1;
          end
        end
        WR1: begin
          if (writeAccepted) begin
            wdata_q <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            seq_q   <= seq_q + 4'd1;
            state_q <= ACCUM;
          end
        end
        default: begin
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign fifo_in_writedata = wdata_q;
  assign fifo_in_write     = write_q;
  assign drop_count        = drop_q;
  assign busy              = busy_q;

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 Parameter DECIM_LOG2, default 2, log2 of the number of ADC sample sets averaged per output block (legal range 0..4).
REQ-002 clk_50  input  1  system clock, 50 MHz; all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  high: accumulate and emit; low: hold accumulators cleared.
REQ-005 reading0, reading1, reading2  input  12 each  latest ltc2308 conversion results, channels 0..2.
REQ-006 reading_valid  input  1  one-cycle pulse; reading0..2 form a new coherent sample set this cycle.
REQ-007 fifo_in_writedata  output  32  Avalon-MM write data to the FIFO input port.
REQ-008 fifo_in_write  output  1  Avalon-MM write strobe.
REQ-009 fifo_in_waitrequest  input  1  FIFO stall; a write is accepted only in a cycle with fifo_in_write=1 and fifo_in_waitrequest=0.
REQ-010 drop_count  output  16  count of blocks discarded due to backpressure, saturating.
REQ-011 busy  output  1  high while a word pair is pending or being written.

Function
REQ-012 Three accumulators of width 12+DECIM_LOG2 and a sample counter shall add reading0..2 on each cycle where reading_valid=1 and enable=1.
REQ-013 On the 2^DECIM_LOG2-th accepted sample, block-complete: avgN = accN >> DECIM_LOG2 (truncate, no rounding) latched into output registers; accumulators and counter cleared in the same cycle; the completing sample is included in the sums.
REQ-014 FSM states: ACCUM, WR0, WR1; ACCUM -> WR0 on block-complete; WR0 -> WR1 on accepted write; WR1 -> ACCUM on accepted write.
REQ-015 WR0: fifo_in_write=1, fifo_in_writedata = {4'hA, seq[3:0], avg1[11:0], avg0[11:0]}.
REQ-016 WR1: fifo_in_write=1, fifo_in_writedata = {4'h5, seq[3:0], 12'h000, avg2[11:0]}.
REQ-017 fifo_in_write and fifo_in_writedata shall be registered and held stable while fifo_in_waitrequest=1; fifo_in_write=0 in ACCUM.
REQ-018 Latency: fifo_in_write asserts the cycle after the block-completing reading_valid; with no stall, WR0 and WR1 occupy consecutive cycles.
REQ-019 Accumulation shall continue during WR0/WR1; a block completing while not in ACCUM shall be discarded (averages not overwritten) and drop_count incremented by 1, saturating at 16'hFFFF.
REQ-020 A block completing in the same cycle as WR1's accepted write shall be discarded (FSM not yet in ACCUM).
REQ-021 seq (4-bit) shall increment on WR1 acceptance, wrapping 15 -> 0; dropped blocks do not advance seq.
REQ-022 enable=0 shall clear accumulators and sample counter and ignore reading_valid; a word pair already in WR0/WR1 shall complete normally.
REQ-023 busy = 1 in WR0 and WR1, 0 in ACCUM.

Reset
REQ-024 reset_n=0 shall asynchronously force: state ACCUM, accumulators 0, sample counter 0, averages 0, seq 0, drop_count 0, fifo_in_write 0, fifo_in_writedata 0, busy 0.
REQ-025 Reset asserted mid-write shall abandon the pair; after release no partial word shall be reissued.

Verification
REQ-026 DECIM_LOG2=2, no stall; 4 valids with reading0=100,104,108,112, reading1=0x800, reading2=0xFFF -> cycle after 4th valid fifo_in_writedata=0xA080006A, next cycle 0x50000FFF, then fifo_in_write=0.
REQ-027 reading0=0,0,0,3 -> avg0=0 (truncation); 4 valids of 0xFFF on all channels -> 0xA0FFFFFF then 0x50000FFF (no overflow).
REQ-028 fifo_in_waitrequest=1 for 10 cycles during WR0 -> fifo_in_writedata and fifo_in_write stable all 10 cycles; word accepted on first low cycle; WR1 follows.
REQ-029 reading_valid every cycle, waitrequest held high 40 cycles -> drop_count increments once per 4 valids after the first block; seq advances by 1 per emitted pair only.
REQ-030 17 emitted pairs -> seq fields 0..15 then 0; drop_count preloaded to 0xFFFF by forced drops stays 0xFFFF.
REQ-031 reset_n pulsed low during WR0 stall, and enable dropped after 2 of 4 valids -> all outputs zero immediately; next output pair reflects only samples after re-enable/reset.
